bram_port_arbiter: RTL
======================

Name: bram_port_arbiter

Overview:
- Shares one simple-dual-port block RAM (1-cycle registered read, synchronous write) between two read clients and two write clients.
- Example pairing: capture writer plus correction-table loader on the write side; demodulator plus host readback on the read side.
- Arbitrates each RAM port independently with round-robin.
- Tags returned read data back to the issuing client with a fixed latency.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDRESS_WIDTH, 8, RAM address width.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- rd0_req  in  1  client 0 read request.
- rd0_addr  in  ADDRESS_WIDTH  client 0 read address.
- rd0_gnt  out  1  client 0 read accepted this cycle.
- rd0_valid  out  1  client 0 read data valid.
- rd0_data  out  DATA_WIDTH  client 0 read data.
- rd1_req, rd1_addr, rd1_gnt, rd1_valid, rd1_data: same as client 0, for client 1.
- wr0_req  in  1  client 0 write request.
- wr0_addr  in  ADDRESS_WIDTH  client 0 write address.
- wr0_data  in  DATA_WIDTH  client 0 write data.
- wr0_gnt  out  1  client 0 write accepted this cycle.
- wr1_req, wr1_addr, wr1_data, wr1_gnt: same as client 0, for client 1.
- ram_read_address  out  ADDRESS_WIDTH  to RAM read port.
- ram_read_data  in  DATA_WIDTH  from RAM, valid one cycle after address.
- ram_write_enable  out  1  to RAM.
- ram_write_address  out  ADDRESS_WIDTH  to RAM.
- ram_write_data  out  DATA_WIDTH  to RAM.

Behaviour:
- Reset:
  - One clock, clk.
  - reset_n is asynchronous assert, synchronous deassert at the system level, active low.
  - While reset_n is low, all gnt outputs are 0 and ram_write_enable is 0.
  - rd0_valid, rd1_valid and both rd_data outputs reset to 0.
  - Held ram_read_address, ram_write_address and ram_write_data reset to 0.
  - Both round-robin pointers reset to "client 1 last served", so client 0 wins the first contention.
- Grant (each port independently):
  - gnt is combinational from req and the pointer in the same cycle.
  - A transfer occurs when req && gnt.
  - Exactly one req high: that client is granted.
  - Both high: grant the client not served last.
  - Neither high: no grant.
  - The pointer updates at the clock edge only when a grant occurred.
  - A client may hold req high across cycles; each granted cycle is one transfer.
  - Requests are never queued; an ungranted req must be held by the client.
- Read path:
  - Cycle T: granted address drives ram_read_address, and the client tag is registered into stage 1.
  - T+1: ram_read_data is valid; the tag moves to stage 2 and ram_read_data is registered.
  - T+2: rdN_valid=1 and rdN_data are presented for exactly one cycle. Fixed latency is 2 cycles from grant to valid.
  - Back-to-back grants give one result per cycle, in grant order; valid and data for client N appear only on rdN outputs.
  - rdN_data holds its last value when valid=0.
  - No grant: ram_read_address holds the last granted address.
- Write path:
  - Cycle T: ram_write_enable=1 with the granted client's addr/data, combinational; the RAM writes at the T edge.
  - No grant: ram_write_enable=0, address/data hold last granted values.
- Hazards:
  - Read and write to the same address in the same cycle returns the old RAM contents; no forwarding.
  - A read granted in the cycle after the write returns new data.
  - Clients own ordering.
- Reset mid-operation:
  - In-flight read tags are cleared, so no stale rd_valid is emitted after reset.
  - Any write not yet clocked is dropped.
- Widths: addresses and data are passed through unmodified; no arithmetic.

Test Plan:
- Reset then single write: wr0_req=1, addr=0x10, data=0xA5 for one cycle -> wr0_gnt=1 that cycle, ram_write_enable=1 with 0x10/0xA5, then 0.
- Single read: rd1_req=1, addr=0x10 at cycle T (RAM model holds 0xA5) -> rd1_gnt=1 at T; rd1_valid=1, rd1_data=0xA5 at T+2 only; rd0_valid stays 0.
- Read contention: rd0_req and rd1_req held high for 4 cycles after reset -> grants 0,1,0,1; valids alternate on rd0/rd1 with the matching data at 2-cycle latency.
- Write contention with one dropout: both wr_req high, wr1 drops for one cycle -> client 0 granted at cycle 1, then client 1, then client 0 alone; the pointer advances only on grants.
- Same-address read and write in one cycle: addr 0x20 old=0x11, write 0x22 -> read returns 0x11; a read one cycle later returns 0x22.
- Reset mid-read: assert reset_n=0 the cycle after a read grant -> no rd_valid pulse after reset release, and client 0 wins the next contention.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Shares one simple-dual-port block RAM between two read clients and two
// write clients. Each RAM port has its own round-robin arbiter. Read data
// comes back to the issuing client two cycles after its grant.
module bram_port_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     rd0_req,
    input  logic [ADDRESS_WIDTH-1:0] rd0_addr,
    output logic                     rd0_gnt,
    output logic                     rd0_valid,
    output logic [DATA_WIDTH-1:0]    rd0_data,

    input  logic                     rd1_req,
    input  logic [ADDRESS_WIDTH-1:0] rd1_addr,
    output logic                     rd1_gnt,
    output logic                     rd1_valid,
    output logic [DATA_WIDTH-1:0]    rd1_data,

    input  logic                     wr0_req,
    input  logic [ADDRESS_WIDTH-1:0] wr0_addr,
    input  logic [DATA_WIDTH-1:0]    wr0_data,
    output logic                     wr0_gnt,

    input  logic                     wr1_req,
    input  logic [ADDRESS_WIDTH-1:0] wr1_addr,
    input  logic [DATA_WIDTH-1:0]    wr1_data,
    output logic                     wr1_gnt,

    output logic [ADDRESS_WIDTH-1:0] ram_read_address,
    input  logic [DATA_WIDTH-1:0]    ram_read_data,
    output logic                     ram_write_enable,
    output logic [ADDRESS_WIDTH-1:0] ram_write_address,
    output logic [DATA_WIDTH-1:0]    ram_write_data
);

    typedef enum logic {
        CLIENT_0 = 1'b0,
        CLIENT_1 = 1'b1
    } client_e;

    // Round-robin pointers hold the client served last on each port.
    client_e                  rd_last_q, rd_last_d;
    client_e                  wr_last_q, wr_last_d;

    logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;

    // Stage 1: tag of the read whose data the RAM returns next cycle.
    logic                     s1_valid_q, s1_valid_d;
    client_e                  s1_tag_q, s1_tag_d;

    // Stage 2: registered results per client.
    logic                     rd0_valid_q, rd0_valid_d;
    logic                     rd1_valid_q, rd1_valid_d;
    logic [DATA_WIDTH-1:0]    rd0_data_q, rd0_data_d;
    logic [DATA_WIDTH-1:0]    rd1_data_q, rd1_data_d;

    // Grants: a lone requester wins, on contention the client not served last.
    always_comb begin
        rd0_gnt = reset_n & rd0_req & (~rd1_req | (rd_last_q == CLIENT_1));
        rd1_gnt = reset_n & rd1_req & (~rd0_req | (rd_last_q == CLIENT_0));
        wr0_gnt = reset_n & wr0_req & (~wr1_req | (wr_last_q == CLIENT_1));
        wr1_gnt = reset_n & wr1_req & (~wr0_req | (wr_last_q == CLIENT_0));
    end

    // Read port: steer the granted address, tag it, and return data to its client.
    always_comb begin
        rd_last_d   = rd_last_q;
        rd_addr_d   = rd_addr_q;
        s1_valid_d  = rd0_gnt | rd1_gnt;
        s1_tag_d    = rd1_gnt ? CLIENT_1 : CLIENT_0;
        if (rd0_gnt) begin
            rd_last_d = CLIENT_0;
            rd_addr_d = rd0_addr;
        end else if (rd1_gnt) begin
            rd_last_d = CLIENT_1;
            rd_addr_d = rd1_addr;
        end
        rd0_valid_d = s1_valid_q & (s1_tag_q == CLIENT_0);
        rd1_valid_d = s1_valid_q & (s1_tag_q == CLIENT_1);
        rd0_data_d  = rd0_valid_d ? ram_read_data : rd0_data_q;
        rd1_data_d  = rd1_valid_d ? ram_read_data : rd1_data_q;
    end

    // Write port: pass the granted client's address/data, hold them otherwise.
    always_comb begin
        wr_last_d = wr_last_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (wr0_gnt) begin
            wr_last_d = CLIENT_0;
            wr_addr_d = wr0_addr;
            wr_data_d = wr0_data;
        end else if (wr1_gnt) begin
            wr_last_d = CLIENT_1;
            wr_addr_d = wr1_addr;
            wr_data_d = wr1_data;
        end
    end

    // State registers; reset points both arbiters at client 1 so client 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_last_q   <= CLIENT_1;
            wr_last_q   <= CLIENT_1;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= CLIENT_0;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
            rd0_data_q  <= '0;
            rd1_data_q  <= '0;
        end else begin
            rd_last_q   <= rd_last_d;
            wr_last_q   <= wr_last_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            s1_valid_q  <= s1_valid_d;
            s1_tag_q    <= s1_tag_d;
            rd0_valid_q <= rd0_valid_d;
            rd1_valid_q <= rd1_valid_d;
            rd0_data_q  <= rd0_data_d;
            rd1_data_q  <= rd1_data_d;
        end
    end

    assign ram_read_address  = rd_addr_d;
    assign ram_write_enable  = wr0_gnt | wr1_gnt;
    assign ram_write_address = wr_addr_d;
    assign ram_write_data    = wr_data_d;
    assign rd0_valid         = rd0_valid_q;
    assign rd1_valid         = rd1_valid_q;
    assign rd0_data          = rd0_data_q;
    assign rd1_data          = rd1_data_q;

endmodule
